// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the outputs, and the skid entry absorbs one entry of back-pressure.
module mem_wb_pipe #(
   parameter int DATA_W        = 32,
   parameter int REG_AW        = 5,
   parameter bit ZERO_SUPPRESS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              ctrl_regWrite_ex_mem,
   input  logic              ctrl_memToReg_ex_mem,
   input  logic [DATA_W-1:0] alu_result_ex_mem,
   input  logic [DATA_W-1:0] read_data_from_mem,
   input  logic [REG_AW-1:0] write_register_ex_mem,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ctrl_regWrite_mem_wb,
   output logic              ctrl_memToReg_mem_wb,
   output logic [DATA_W-1:0] alu_result_mem_wb,
   output logic [DATA_W-1:0] read_data_from_mem_mem_wb,
   output logic [REG_AW-1:0] write_register_mem_wb,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_en,
   output logic [1:0]        occupancy
);

   logic              skid_valid;
   logic              skid_regWrite;
   logic              skid_memToReg;
   logic [DATA_W-1:0] skid_alu;
   logic [DATA_W-1:0] skid_mem;
   logic [REG_AW-1:0] skid_rd;

   logic              accept;
   logic              pop;
   logic              cap_regWrite;
   logic [1:0]        occupancy_next;

   // A write to register 0 is architecturally a no-op, so its enable is dropped once at capture.
   function automatic logic capture_regwrite(input logic rw, input logic [REG_AW-1:0] rd);
      return rw & ~(ZERO_SUPPRESS & (rd == '0));
   endfunction

   assign in_ready     = ~skid_valid;
   assign accept       = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign cap_regWrite = capture_regwrite(ctrl_regWrite_ex_mem, write_register_ex_mem);

   assign wb_data = ctrl_memToReg_mem_wb ? read_data_from_mem_mem_wb : alu_result_mem_wb;
   // Gated by reset so that a pop cycle which is being reset cannot commit a write.
   assign wb_en   = out_valid & out_ready & ctrl_regWrite_mem_wb & ~reset;

   always_comb begin
      occupancy_next = occupancy;
      case ({accept, pop})
         2'b10:   occupancy_next = occupancy + 2'd1;
         2'b01:   occupancy_next = occupancy - 2'd1;
         default: occupancy_next = occupancy;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid                 <= 1'b0;
         ctrl_regWrite_mem_wb      <= 1'b0;
         ctrl_memToReg_mem_wb      <= 1'b0;
         alu_result_mem_wb         <= '0;
         read_data_from_mem_mem_wb <= '0;
         write_register_mem_wb     <= '0;
         skid_valid                <= 1'b0;
         skid_regWrite             <= 1'b0;
         skid_memToReg             <= 1'b0;
         skid_alu                  <= '0;
         skid_mem                  <= '0;
         skid_rd                   <= '0;
         occupancy                 <= 2'd0;
      end else if (flush) begin
         out_valid            <= 1'b0;
         ctrl_regWrite_mem_wb <= 1'b0;
         skid_valid           <= 1'b0;
         skid_regWrite        <= 1'b0;
         occupancy            <= 2'd0;
      end else begin
         if (pop && skid_valid) begin
            // in_ready is low here, so no new entry can arrive in the same cycle.
            out_valid                 <= 1'b1;
            ctrl_regWrite_mem_wb      <= skid_regWrite;
            ctrl_memToReg_mem_wb      <= skid_memToReg;
            alu_result_mem_wb         <= skid_alu;
            read_data_from_mem_mem_wb <= skid_mem;
            write_register_mem_wb     <= skid_rd;
            skid_valid                <= 1'b0;
            skid_regWrite             <= 1'b0;
         end else if (accept && (!out_valid || pop)) begin
            out_valid                 <= 1'b1;
            ctrl_regWrite_mem_wb      <= cap_regWrite;
            ctrl_memToReg_mem_wb      <= ctrl_memToReg_ex_mem;
            alu_result_mem_wb         <= alu_result_ex_mem;
            read_data_from_mem_mem_wb <= read_data_from_mem;
            write_register_mem_wb     <= write_register_ex_mem;
         end else if (accept) begin
            skid_valid    <= 1'b1;
            skid_regWrite <= cap_regWrite;
            skid_memToReg <= ctrl_memToReg_ex_mem;
            skid_alu      <= alu_result_ex_mem;
            skid_mem      <= read_data_from_mem;
            skid_rd       <= write_register_ex_mem;
         end else if (pop) begin
            out_valid            <= 1'b0;
            ctrl_regWrite_mem_wb <= 1'b0;
         end
         occupancy <= occupancy_next;
      end
   end

endmodule
